vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between the VGA scan-out path and a pixel writer (drawing engine/CPU).
- Sits between the VGA timing module (consumes its x/y/sync outputs) and the colour outputs in TOP; replaces the fixed test-square logic with buffer data.
- Video reads always take priority. Writes use the free RAM cycles.
- Framebuffer is FB_W x FB_H, upscaled by 2^SCALE_SH onto 640x480.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
SCALE_SH, 2, log2 upscale factor (framebuffer pixel = 4x4 screen pixels)
PIX_W, 3, bits per pixel ({R,G,B} MSBs)
ADDR_W, 15, RAM address width; FB_W*FB_H must be <= 2^ADDR_W

Ports:
in_clock  in  1  system clock (50 MHz)
in_reset  in  1  synchronous reset, active-high
in_strobe  in  1  pixel strobe, one clock wide, at most every 2nd clock
in_x  in  10  current screen column from the VGA timing module
in_y  in  9  current screen row
in_hsync  in  1  hsync from the VGA timing module
in_vsync  in  1  vsync from the VGA timing module
in_wr_req  in  1  write request, level; held with addr/data until ack
in_wr_addr  in  ADDR_W  write address (row*FB_W+col)
in_wr_data  in  PIX_W  write pixel
out_wr_ack  out  1  one-clock pulse: write performed or dropped
out_ram_en  out  1  RAM port enable
out_ram_we  out  1  RAM write enable
out_ram_addr  out  ADDR_W  RAM address
out_ram_wdata  out  PIX_W  RAM write data
in_ram_rdata  in  PIX_W  RAM read data, valid 1 clock after the address cycle
out_pixel  out  PIX_W  colour to the DAC
out_hsync  out  1  hsync delayed to match out_pixel
out_vsync  out  1  vsync delayed to match out_pixel

Behaviour:
- Reset (in_reset=1 at a clock edge): state IDLE; out_ram_en/we=0; out_wr_ack=0; out_pixel=0; out_hsync=out_vsync=1 (inactive); pipeline valid flags cleared. A write in flight is aborted without ack.
- visible = (in_x<640)&(in_y<480).
- fb_addr = (in_y>>SCALE_SH)*FB_W + (in_x>>SCALE_SH), computed in ADDR_W bits. There is no wrap; the visible area maps exactly onto the framebuffer.
- Port FSM, evaluated at every clock edge, registered outputs. Priority order:
  - VREAD if in_strobe & visible: ram_en=1, we=0, addr=fb_addr.
  - WRITE if in_wr_req & !ack_block: ram_en=1. If in_wr_addr < FB_W*FB_H then we=1, addr=in_wr_addr, wdata=in_wr_data; otherwise we=0 (dropped). out_wr_ack=1 in the same cycle.
  - IDLE otherwise: en=0, we=0, ack=0.
- ack_block=1 during any cycle in which out_wr_ack=1. No write is granted on the edge closing an ack cycle, so a held request cannot be written twice. The minimum write spacing is 2 clocks.
- Writes can run on any clock edge that has no visible strobe, including strobe edges during blanking.
- Worst-case write latency is 2 clocks from request, given the strobe spacing rule.
- Video pipeline (stages advance only on in_strobe edges):
  - Stage 1 captures in_hsync, in_vsync and visible.
  - Stage 2 loads out_pixel = visible_d1 ? in_ram_rdata : 0, and loads out_hsync/out_vsync from stage 1.
  - Total video latency is 2 strobes; pixel and syncs stay aligned.
- in_ram_rdata is sampled only at strobe edges whose previous cycle was VREAD.

Optional Feature:
- Macro VGA_FB_BORDER_EN.
- Defined: stage 2 forces out_pixel={PIX_W{1'b1}} when the delayed position has x==0, x==639, y==0 or y==479. RAM traffic is unchanged. Needs x/y edge flags carried through stage 1.
- Undefined: no border logic; out_pixel comes purely from the buffer.

Test Plan:
- Reset: assert in_reset 2 clocks mid-frame -> out_pixel=0, out_hsync=out_vsync=1, out_ram_en=0, out_wr_ack=0 on the next edge.
- Scan read: preload addr0=3'b100, addr161=3'b010; strobe at (0,0) -> ram_addr=0 next clock, out_pixel=3'b100 two strobes later aligned with delayed sync. Strobe at (4,4) -> addr 161, pixel 3'b010. Strobe at (639,479) -> addr 19199.
- Blanking write: in_x=700, req addr 5 data 3'b011 -> next clock we=1, addr=5, ack=1. Holding req -> no second ack for 1 clock, and the second write occurs on the 2nd clock after the first ack.
- Conflict: req raised on a visible strobe edge -> VREAD first, write in the following clock, ack <=2 clocks after request. Video pixel still correct.
- Out-of-range: req addr 19200 -> ack=1, out_ram_we=0.
- Reset mid-write: req pending, reset on the grant edge -> no ack, we=0. With VGA_FB_BORDER_EN, strobe at (0,100) -> out_pixel=3'b111 regardless of RAM.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: video scan-out reads take priority, and pixel writes use the free RAM cycles.
// Optional VGA_FB_BORDER_EN macro draws a one-pixel white frame around the visible area.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | RAM port unused this cycle
// ST_VREAD | video read of fb_addr presented to the RAM
// ST_WRITE | write grant (we=1) or dropped out-of-range write (we=0), ack high
module vga_fb_arbiter #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE_SH = 2,
    parameter int PIX_W    = 3,
    parameter int ADDR_W   = 15
) (
    input  logic              in_clock,
    input  logic              in_reset,
    input  logic              in_strobe,
    input  logic [9:0]        in_x,
    input  logic [8:0]        in_y,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_wr_req,
    input  logic [ADDR_W-1:0] in_wr_addr,
    input  logic [PIX_W-1:0]  in_wr_data,
    output logic              out_wr_ack,
    output logic              out_ram_en,
    output logic              out_ram_we,
    output logic [ADDR_W-1:0] out_ram_addr,
    output logic [PIX_W-1:0]  out_ram_wdata,
    input  logic [PIX_W-1:0]  in_ram_rdata,
    output logic [PIX_W-1:0]  out_pixel,
    output logic              out_hsync,
    output logic              out_vsync
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VREAD = 2'd1,
        ST_WRITE = 2'd2
    } port_state_t;

    localparam logic [ADDR_W:0]   FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);

    port_state_t       state_q, state_d;
    logic              en_d, we_d, ack_d;
    logic [ADDR_W-1:0] addr_d;
    logic [PIX_W-1:0]  wdata_d;

    logic              visible;
    logic [ADDR_W-1:0] fb_addr;
    logic              wr_in_range;

    logic              hsync_d1, vsync_d1, visible_d1;
    logic              rd_valid_q;
    logic [PIX_W-1:0]  rd_hold;
    logic [PIX_W-1:0]  rd_data;
    logic [PIX_W-1:0]  pixel_next;

    assign visible     = (in_x < 10'd640) && (in_y < 9'd480);
    assign fb_addr     = ADDR_W'(in_y >> SCALE_SH) * FB_W_A + ADDR_W'(in_x >> SCALE_SH);
    assign wr_in_range = {1'b0, in_wr_addr} < FB_SIZE;

    // out_wr_ack doubles as the ack block, so a held request waits one cycle before regranting.
    always_comb begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        addr_d  = out_ram_addr;
        wdata_d = out_ram_wdata;
        if (in_strobe && visible) begin
            state_d = ST_VREAD;
            en_d    = 1'b1;
            addr_d  = fb_addr;
        end else if (in_wr_req && !out_wr_ack) begin
            state_d = ST_WRITE;
            en_d    = 1'b1;
            ack_d   = 1'b1;
            if (wr_in_range) begin
                we_d    = 1'b1;
                addr_d  = in_wr_addr;
                wdata_d = in_wr_data;
            end
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q       <= ST_IDLE;
            out_ram_en    <= 1'b0;
            out_ram_we    <= 1'b0;
            out_wr_ack    <= 1'b0;
            out_ram_addr  <= '0;
            out_ram_wdata <= '0;
        end else begin
            state_q       <= state_d;
            out_ram_en    <= en_d;
            out_ram_we    <= we_d;
            out_wr_ack    <= ack_d;
            out_ram_addr  <= addr_d;
            out_ram_wdata <= wdata_d;
        end
    end

    // Read data is held after its valid cycle so a later write cannot disturb it before the next strobe.
    assign rd_data = rd_valid_q ? in_ram_rdata : rd_hold;

`ifdef VGA_FB_BORDER_EN
    logic border;
    logic border_d1;

    // Border is limited to the visible area so blanking stays black at the DAC.
    assign border = visible &&
                    ((in_x == 10'd0) || (in_x == 10'd639) ||
                     (in_y == 9'd0)  || (in_y == 9'd479));

    always_comb begin
        pixel_next = visible_d1 ? rd_data : '0;
        if (border_d1) begin
            pixel_next = '1;
        end
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            border_d1 <= 1'b0;
        end else if (in_strobe) begin
            border_d1 <= border;
        end
    end
`else
    always_comb begin
        pixel_next = visible_d1 ? rd_data : '0;
    end
`endif

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            hsync_d1   <= 1'b1;
            vsync_d1   <= 1'b1;
            visible_d1 <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hold    <= '0;
            out_pixel  <= '0;
            out_hsync  <= 1'b1;
            out_vsync  <= 1'b1;
        end else begin
            rd_valid_q <= (state_q == ST_VREAD);
            if (rd_valid_q) begin
                rd_hold <= in_ram_rdata;
            end
            if (in_strobe) begin
                hsync_d1   <= in_hsync;
                vsync_d1   <= in_vsync;
                visible_d1 <= visible;
                out_pixel  <= pixel_next;
                out_hsync  <= hsync_d1;
                out_vsync  <= vsync_d1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: vector table for scan reads, scoreboard for the video
// pipeline, and hand-written sequences for write timing, conflicts and reset.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 15;
    localparam int PIX_W  = 3;

    logic              in_clock = 1'b0;
    logic              in_reset;
    logic              in_strobe;
    logic [9:0]        in_x;
    logic [8:0]        in_y;
    logic              in_hsync;
    logic              in_vsync;
    logic              in_wr_req;
    logic [ADDR_W-1:0] in_wr_addr;
    logic [PIX_W-1:0]  in_wr_data;
    logic              out_wr_ack;
    logic              out_ram_en;
    logic              out_ram_we;
    logic [ADDR_W-1:0] out_ram_addr;
    logic [PIX_W-1:0]  out_ram_wdata;
    logic [PIX_W-1:0]  in_ram_rdata;
    logic [PIX_W-1:0]  out_pixel;
    logic              out_hsync;
    logic              out_vsync;

    vga_fb_arbiter dut (
        .in_clock      (in_clock),
        .in_reset      (in_reset),
        .in_strobe     (in_strobe),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_hsync      (in_hsync),
        .in_vsync      (in_vsync),
        .in_wr_req     (in_wr_req),
        .in_wr_addr    (in_wr_addr),
        .in_wr_data    (in_wr_data),
        .out_wr_ack    (out_wr_ack),
        .out_ram_en    (out_ram_en),
        .out_ram_we    (out_ram_we),
        .out_ram_addr  (out_ram_addr),
        .out_ram_wdata (out_ram_wdata),
        .in_ram_rdata  (in_ram_rdata),
        .out_pixel     (out_pixel),
        .out_hsync     (out_hsync),
        .out_vsync     (out_vsync)
    );

    always #10 in_clock = ~in_clock;

    // Single-port synchronous RAM model, read-first, with a bench preload port.
    logic [PIX_W-1:0]  mem [0:32767];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [PIX_W-1:0]  pre_data;

    always @(posedge in_clock) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (out_ram_en) begin
            if (out_ram_we) mem[out_ram_addr] <= out_ram_wdata;
            in_ram_rdata <= mem[out_ram_addr];
        end
    end

    logic [PIX_W-1:0] gold [0:32767];

    typedef struct {
        logic [PIX_W-1:0] pix;
        logic             hs;
        logic             vs;
    } px_exp_t;

    typedef struct {
        logic [9:0]        x;
        logic [8:0]        y;
        logic              hs;
        logic              vs;
        logic              en;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    px_exp_t sb[$];
    vec_t    vecs [9];
    int      n_vec = 0;
    int      n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    function automatic logic [PIX_W-1:0] model_pixel(input logic [9:0] x, input logic [8:0] y);
        int a;
        logic [PIX_W-1:0] p;
        if (!(x < 10'd640 && y < 9'd480)) return '0;
        a = (int'(y) / 4) * 160 + int'(x) / 4;
        p = gold[a];
`ifdef VGA_FB_BORDER_EN
        if (x == 10'd0 || x == 10'd639 || y == 9'd0 || y == 9'd479) p = '1;
`endif
        return p;
    endfunction

    task automatic sb_reset();
        px_exp_t e;
        sb.delete();
        e.pix = '0; e.hs = 1'b1; e.vs = 1'b1;
        sb.push_back(e);
    endtask

    // Drives one strobe, then compares the pipeline output against the entry two strobes back.
    task automatic do_strobe(input logic [9:0] x, input logic [8:0] y, input logic hs, input logic vs);
        px_exp_t e;
        e.pix = model_pixel(x, y); e.hs = hs; e.vs = vs;
        sb.push_back(e);
        in_strobe = 1'b1; in_x = x; in_y = y; in_hsync = hs; in_vsync = vs;
        tick();
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("pixel", int'(out_pixel), int'(e.pix));
            check("hsync_out", int'(out_hsync), int'(e.hs));
            check("vsync_out", int'(out_vsync), int'(e.vs));
        end
        in_strobe = 1'b0;
    endtask

    task automatic preload(input int a, input logic [PIX_W-1:0] d);
        pre_we = 1'b1; pre_addr = ADDR_W'(a); pre_data = d;
        gold[a] = d;
        tick();
        pre_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) gold[i] = '0;
        in_reset = 1'b1; in_strobe = 1'b0; in_x = 10'd700; in_y = 9'd10;
        in_hsync = 1'b1; in_vsync = 1'b1; in_wr_req = 1'b0; in_wr_addr = '0; in_wr_data = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        vecs[0] = '{10'd0,   9'd0,   1'b1, 1'b1, 1'b1, 15'd0};
        vecs[1] = '{10'd4,   9'd4,   1'b0, 1'b1, 1'b1, 15'd161};
        vecs[2] = '{10'd639, 9'd479, 1'b1, 1'b0, 1'b1, 15'd19199};
        vecs[3] = '{10'd700, 9'd10,  1'b0, 1'b1, 1'b0, 15'd0};
        vecs[4] = '{10'd320, 9'd240, 1'b1, 1'b1, 1'b1, 15'd9680};
        vecs[5] = '{10'd100, 9'd500, 1'b1, 1'b0, 1'b0, 15'd0};
        vecs[6] = '{10'd7,   9'd3,   1'b0, 1'b0, 1'b1, 15'd1};
        vecs[7] = '{10'd12,  9'd300, 1'b1, 1'b1, 1'b1, 15'd12003};
        vecs[8] = '{10'd0,   9'd100, 1'b0, 1'b1, 1'b1, 15'd4000};

        // Reset state.
        tick(); tick();
        check("rst_pixel", int'(out_pixel), 0);
        check("rst_hsync", int'(out_hsync), 1);
        check("rst_vsync", int'(out_vsync), 1);
        check("rst_ram_en", int'(out_ram_en), 0);
        check("rst_ram_we", int'(out_ram_we), 0);
        check("rst_ack", int'(out_wr_ack), 0);

        preload(0, 3'b100);     preload(161, 3'b010);  preload(19199, 3'b101);
        preload(9680, 3'b110);  preload(1, 3'b001);    preload(12003, 3'b111);
        preload(4000, 3'b011);  preload(2, 3'b110);
        in_reset = 1'b0;
        sb_reset();
        tick();

        // Scan reads from the vector table; uneven spacing exercises the held read data.
        for (int i = 0; i < 9; i++) begin
            do_strobe(vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs);
            check("vread_en", int'(out_ram_en), int'(vecs[i].en));
            if (vecs[i].en) begin
                check("vread_addr", int'(out_ram_addr), int'(vecs[i].addr));
                check("vread_we", int'(out_ram_we), 0);
            end
            repeat (1 + 2 * (i % 2)) tick();
        end
        do_strobe(10'd700, 9'd20, 1'b1, 1'b1);
        tick();

        // Blanking write with a held request.
        in_x = 10'd700; in_y = 9'd20;
        in_wr_req = 1'b1; in_wr_addr = 15'd5; in_wr_data = 3'b011; gold[5] = 3'b011;
        tick();
        check("wr1_ack", int'(out_wr_ack), 1);
        check("wr1_we", int'(out_ram_we), 1);
        check("wr1_addr", int'(out_ram_addr), 5);
        check("wr1_wdata", int'(out_ram_wdata), 3);
        tick();
        check("wr_hold_ack", int'(out_wr_ack), 0);
        check("wr_hold_en", int'(out_ram_en), 0);
        tick();
        check("wr2_ack", int'(out_wr_ack), 1);
        check("wr2_we", int'(out_ram_we), 1);
        in_wr_req = 1'b0;
        tick();
        check("wr_release_ack", int'(out_wr_ack), 0);
        check("mem5", int'(mem[5]), 3);

        // Request raised on a visible strobe edge: video read first, write next clock.
        in_wr_req = 1'b1; in_wr_addr = 15'd300; in_wr_data = 3'b101; gold[300] = 3'b101;
        do_strobe(10'd8, 9'd0, 1'b0, 1'b1);
        check("cf_en", int'(out_ram_en), 1);
        check("cf_we", int'(out_ram_we), 0);
        check("cf_addr", int'(out_ram_addr), 2);
        check("cf_ack_early", int'(out_wr_ack), 0);
        tick();
        check("cf_ack", int'(out_wr_ack), 1);
        check("cf_wr_we", int'(out_ram_we), 1);
        check("cf_wr_addr", int'(out_ram_addr), 300);
        check("cf_wr_data", int'(out_ram_wdata), 5);
        in_wr_req = 1'b0;
        tick();
        do_strobe(10'd700, 9'd0, 1'b1, 1'b0);
        tick();
        check("mem300", int'(mem[300]), 5);

        // Out-of-range write is dropped but acknowledged; last in-range address is written.
        in_wr_req = 1'b1; in_wr_addr = 15'd19200; in_wr_data = 3'b111;
        tick();
        check("oor_ack", int'(out_wr_ack), 1);
        check("oor_we", int'(out_ram_we), 0);
        in_wr_req = 1'b0;
        tick();
        in_wr_req = 1'b1; in_wr_addr = 15'd19199; in_wr_data = 3'b001; gold[19199] = 3'b001;
        tick();
        check("edge_ack", int'(out_wr_ack), 1);
        check("edge_we", int'(out_ram_we), 1);
        in_wr_req = 1'b0;
        tick();
        check("mem19199", int'(mem[19199]), 1);

        // Reset mid-frame while a write is pending on the grant edge.
        do_strobe(10'd0, 9'd0, 1'b0, 1'b0);
        tick();
        do_strobe(10'd700, 9'd0, 1'b0, 1'b0);
        in_wr_req = 1'b1; in_wr_addr = 15'd7; in_wr_data = 3'b010;
        in_reset = 1'b1;
        tick();
        check("rstw_ack", int'(out_wr_ack), 0);
        check("rstw_we", int'(out_ram_we), 0);
        check("rstw_en", int'(out_ram_en), 0);
        tick();
        check("rstw_pixel", int'(out_pixel), 0);
        check("rstw_hsync", int'(out_hsync), 1);
        check("rstw_vsync", int'(out_vsync), 1);
        in_reset = 1'b0; in_wr_req = 1'b0;
        sb_reset();
        tick();
        do_strobe(10'd8, 9'd0, 1'b1, 1'b1);
        tick();
        do_strobe(10'd700, 9'd0, 1'b1, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
